// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the alu_seq operation sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MUL      = 3'd2,
    S_DIV_INIT = 3'd3,
    S_DIV_WAIT = 3'd4,
    S_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/alu_seq_mult_sa.sv
// W-iteration shift-add multiplier (mult_sa): load clears the accumulator, each step
// consumes one multiplier LSB. product_o is the accumulator value after the current step.
module alu_seq_mult_sa #(
  parameter int W = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o,
  output logic           done_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // done_o flags the step that completes the W-th iteration, so the caller can
  // capture product_o on that same edge.
  assign product_o = acc_d;
  assign done_o    = step_i && !load_i && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Operation sequencer in front of the Lab2 divisor stage: sum/sub locally, multiply via
// the shift-add unit, divide by driving the external divider, then one done pulse.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W             = 3,
  parameter int DIV_INIT_HOLD = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   A_i,
  input  logic [W-1:0]   B_i,
  input  logic [1:0]     op_i,
  input  logic           start_i,
  output logic [W-1:0]   div_a_o,
  output logic [W-1:0]   div_b_o,
  output logic           div_init_o,
  input  logic [W-1:0]   div_q_i,
  output logic [2*W-1:0] result_o,
  output logic           sign_o,
  output logic           err_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int HW = $clog2(DIV_INIT_HOLD + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  op_e            op_q, op_d;
  logic [2*W-1:0] result_q, result_d;
  logic           sign_q, sign_d;
  logic           err_q, err_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           mul_load, mul_step, mul_done;
  logic [2*W-1:0] mul_prod;

  alu_seq_mult_sa #(.W(W)) u_mult (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (a_q),
    .b_i       (b_q),
    .product_o (mul_prod),
    .done_o    (mul_done)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    sign_d   = sign_q;
    err_d    = err_q;
    hold_d   = hold_q;
    mul_load = 1'b0;
    mul_step = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = A_i;
          b_d     = B_i;
          op_d    = op_e'(op_i);
          sign_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_SUM: begin
            result_d = {{(W-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
            state_d  = S_DONE;
          end
          OP_SUB: begin
            if (a_q >= b_q) begin
              result_d = {{W{1'b0}}, a_q - b_q};
              sign_d   = 1'b0;
            end else begin
              result_d = {{W{1'b0}}, b_q - a_q};
              sign_d   = 1'b1;
            end
            state_d = S_DONE;
          end
          OP_MUL: begin
            mul_load = 1'b1;
            state_d  = S_MUL;
          end
          OP_DIV: begin
            // A zero divisor is flagged here and the divider is never started.
            if (b_q == '0) begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = S_DONE;
            end else begin
              hold_d  = '0;
              state_d = S_DIV_INIT;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_done) begin
          result_d = mul_prod;
          state_d  = S_DONE;
        end
      end
      S_DIV_INIT: begin
        if (hold_q == HW'(DIV_INIT_HOLD - 1)) begin
          hold_d  = '0;
          state_d = S_DIV_WAIT;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DIV_WAIT: begin
        result_d = {{W{1'b0}}, div_q_i};
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_SUM;
      result_q <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  // Divider operands come straight from the capture registers, so they only move on an accepted start.
  assign div_a_o    = a_q;
  assign div_b_o    = b_q;
  assign div_init_o = (state_q == S_DIV_INIT);
  assign result_o   = result_q;
  assign sign_o     = sign_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural model plus directed literal cases,
// with a small model of the downstream divider attached.
module tb_alu_seq;

  localparam int W    = 3;
  localparam int HOLD = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [1:0]     op = '0;
  logic           start = 1'b0;
  logic [W-1:0]   div_a_o, div_b_o, div_q;
  logic           div_init_o;
  logic [2*W-1:0] result_o;
  logic           sign_o, err_o, busy_o, done_o;

  int nChecks = 0;
  int nFail   = 0;
  bit cmpEn   = 0;

  alu_seq #(.W(W), .DIV_INIT_HOLD(HOLD)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .A_i        (A),
    .B_i        (B),
    .op_i       (op),
    .start_i    (start),
    .div_a_o    (div_a_o),
    .div_b_o    (div_b_o),
    .div_init_o (div_init_o),
    .div_q_i    (div_q),
    .result_o   (result_o),
    .sign_o     (sign_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Divider model: loads operands on the first init edge, produces the quotient on the next.
  logic [W-1:0] dvA = '0, dvB = '0;
  bit           dvLoaded = 0;
  initial div_q = '0;
  always @(posedge clk) begin
    if (!rst || !div_init_o) begin
      dvLoaded <= 0;
    end else if (!dvLoaded) begin
      dvA      <= div_a_o;
      dvB      <= div_b_o;
      dvLoaded <= 1;
    end else begin
      div_q <= (dvB != 0) ? W'(dvA / dvB) : '0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: what each accepted op must produce and when.
  bit m_busy = 0, m_div = 0;
  int m_age = 0, m_lat = 0;
  int m_a = 0, m_b = 0;
  int m_res = 0, m_sign = 0, m_err = 0;
  int p_res = 0, p_sign = 0, p_err = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0; m_div = 0; m_age = 0;
      m_a = 0; m_b = 0; m_res = 0; m_sign = 0; m_err = 0;
    end else if (m_busy) begin
      m_age++;
      if (m_age == m_lat - 1) begin
        m_res = p_res; m_sign = p_sign; m_err = p_err;
      end
      if (m_age >= m_lat) m_busy = 0;
    end else if (start) begin
      m_busy = 1; m_age = 0; m_div = 0;
      m_a = int'(A); m_b = int'(B);
      p_sign = 0; p_err = 0;
      case (op)
        2'b00: begin p_res = m_a + m_b; m_lat = 2; end
        2'b01: begin
          p_res  = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
          p_sign = (m_a < m_b) ? 1 : 0;
          m_lat  = 2;
        end
        2'b10: begin p_res = m_a * m_b; m_lat = W + 2; end
        default: begin
          if (m_b == 0) begin p_res = 0; p_err = 1; m_lat = 2; end
          else begin p_res = m_a / m_b; m_div = 1; m_lat = HOLD + 3; end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      bit expDone, expInit;
      expDone = m_busy && (m_age == m_lat - 1);
      expInit = m_busy && m_div && (m_age >= 1) && (m_age <= HOLD);
      checkOutput("busy", int'(busy_o), int'(m_busy));
      checkOutput("done", int'(done_o), int'(expDone));
      checkOutput("div_init", int'(div_init_o), int'(expInit));
      checkOutput("div_a", int'(div_a_o), m_a);
      checkOutput("div_b", int'(div_b_o), m_b);
      if (!m_busy || expDone) begin
        checkOutput("result", int'(result_o), m_res);
        checkOutput("sign", int'(sign_o), m_sign);
        checkOutput("err", int'(err_o), m_err);
      end
    end
  end

  task automatic applyStimulus(input int a, input int b, input int o, input bit s);
    @(posedge clk);
    #2;
    A = W'(a); B = W'(b); op = 2'(o); start = s;
  endtask

  // Directed op with literal expectations for latency, result, flags and init length.
  task automatic runOp(input int a, input int b, input int o, input int expRes,
                       input int expSign, input int expErr, input int expLat,
                       input int expInit, input bit repulse);
    int initCnt = 0;
    int lat = 0;
    bit found = 0;
    applyStimulus(a, b, o, 1'b1);
    @(posedge clk);
    #2 start = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (repulse && i == 1) begin
        A = W'(a + 1); B = W'(b + 2); op = 2'b00; start = 1'b1;
      end
      if (repulse && i == 2) start = 1'b0;
      if (div_init_o) initCnt++;
      if (done_o) begin
        found = 1;
        lat = i + 1;
      end
    end
    if (!found) checkOutput("done_timeout", 0, 1);
    checkOutput("latency", lat, expLat);
    checkOutput("lit_result", int'(result_o), expRes);
    checkOutput("lit_sign", int'(sign_o), expSign);
    checkOutput("lit_err", int'(err_o), expErr);
    checkOutput("init_cycles", initCnt, expInit);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b1; A = 3'd5; B = 3'd3; op = 2'b11;
    @(posedge clk);
    @(posedge clk);
    cmpEn = 1;
    #1;
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_result", int'(result_o), 0);
    checkOutput("rst_div_init", int'(div_init_o), 0);
    checkOutput("rst_div_a", int'(div_a_o), 0);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;

    $display("[TB] directed operations");
    runOp(7, 5, 0, 12, 0, 0, 2, 0, 0);
    runOp(2, 6, 1, 4, 1, 0, 2, 0, 0);
    runOp(7, 7, 2, 49, 0, 0, 5, 0, 0);
    runOp(0, 5, 2, 0, 0, 0, 5, 0, 0);
    runOp(7, 2, 3, 3, 0, 0, 5, 2, 0);
    runOp(6, 3, 3, 2, 0, 0, 5, 2, 0);
    runOp(5, 0, 3, 0, 0, 1, 2, 0, 0);
    runOp(7, 7, 2, 49, 0, 0, 5, 0, 1);

    $display("[TB] reset during divider init");
    applyStimulus(7, 2, 3, 1'b1);
    @(posedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_div_init", int'(div_init_o), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_init", int'(div_init_o), 0);
    checkOutput("mid_rst_busy", int'(busy_o), 0);
    checkOutput("mid_rst_done", int'(done_o), 0);
    @(negedge clk);
    rst = 1'b1;
    runOp(6, 3, 3, 2, 0, 0, 5, 2, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2;
      A     = W'($urandom_range(0, 7));
      B     = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 7));
      op    = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk);
    #2 start = 1'b0; rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
